// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0-3 slave with clk-domain oversampling of sck/ss/mosi,
// double-buffered transmit word and back-to-back frame support.
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;
  logic ss_s1, ss_s2, sck_s1, sck_s2, sck_s3, mosi_s1, mosi_s2;
  logic cpol_l, cpha_l;
  logic [WIDTH-1:0] tx_buf, tx_sr, rx_sr, load_word, rx_next;
  logic [CW-1:0] cnt;
  logic lead, trail, sample, shift, last, enter, run;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = ss_s2 ? IDLE : ACTIVE;
    enter      = (state == IDLE) && !ss_s2;
    run        = (state == ACTIVE) && !ss_s2;
    lead       = (sck_s2 != sck_s3) && (sck_s2 != cpol_l);
    trail      = (sck_s2 != sck_s3) && (sck_s2 == cpol_l);
    sample     = run && (cpha_l ? trail : lead);
    shift      = run && (cpha_l ? lead : trail);
    last       = cnt == CW'(WIDTH - 1);
    load_word  = write ? din : tx_buf;
    rx_next    = {rx_sr[WIDTH-2:0], mosi_s2};
  end
  // cnt==0 on a shift edge marks a frame boundary: cpha=0 reloads there,
  // cpha=1 holds the MSB already presented on miso.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      cnt    <= '0;
      tx_buf <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (write) tx_buf <= din;
      if (enter) begin
        cpol_l <= cpol;
        cpha_l <= cpha;
        cnt    <= '0;
        rx_sr  <= '0;
        tx_sr  <= load_word;
      end
      if (sample) begin
        rx_sr <= rx_next;
        cnt   <= last ? '0 : cnt + 1'b1;
        if (last) begin
          dout  <= rx_next;
          valid <= 1'b1;
        end
        if (last && cpha_l) tx_sr <= load_word;
      end
      if (shift) tx_sr <= (cnt == '0) ? (cpha_l ? tx_sr : load_word) : tx_sr << 1;
    end
  end
  assign busy    = state == ACTIVE;
  assign miso_oe = busy;
  assign miso    = busy & tx_sr[WIDTH-1];
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table-driven SPI master model plus directed abort, latency,
// back-to-back and mid-frame reset sequences.
module tb_spi_slave;
  localparam int HALF = 50;
  logic clk = 1'b0, reset = 1'b1, sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, write = 1'b0;
  logic [7:0] din = 8'h00, dout;
  logic miso, miso_oe, valid, busy;
  int passed = 0, total = 0;
  logic [7:0] vq[$];
  typedef struct {
    logic cpol, cpha;
    logic [7:0] din, mtx, exp_dout, exp_mrx;
  } vec_t;
  vec_t vecs[7];
  spi_slave #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .write(write), .din(din),
    .dout(dout), .valid(valid), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (valid) vq.push_back(dout);
  initial begin
    #1ms;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    write = 1'b1;
    din = d;
    @(negedge clk);
    write = 1'b0;
  endtask
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        #HALF sck = ~cpol;
        rx = {rx[6:0], miso};
        #HALF sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = tx[7-i];
        #HALF sck = cpol;
        rx = {rx[6:0], miso};
        #HALF;
      end
    end
  endtask
  task automatic frame(input logic [7:0] m, output logic [7:0] r);
    @(negedge clk);
    sck = cpol;
    #HALF;
    check("busy_before_ss", busy, 1'b0);
    ss = 1'b0;
    #100;
    xfer(m, 8, r);
    #100;
  endtask
  task automatic release_ss();
    @(negedge clk);
    ss = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    logic [7:0] r, r1, r2, r3;
    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h2A, 8'h2A, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'hA5, 8'h2A, 8'h2A, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'h2A, 8'h2A, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 8'hA5, 8'h2A, 8'h2A, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[6] = '{1'b0, 1'b1, 8'h3C, 8'hC3, 8'hC3, 8'h3C};
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_miso", miso, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      cpol = vecs[i].cpol;
      cpha = vecs[i].cpha;
      wr(vecs[i].din);
      vq.delete();
      frame(vecs[i].mtx, r);
      check("busy_in_frame", busy, 1'b1);
      check("miso_oe_in_frame", miso_oe, 1'b1);
      release_ss();
      check("busy_after", busy, 1'b0);
      check("miso_after", miso, 1'b0);
      check("dout", dout, vecs[i].exp_dout);
      check("valid_count", vq.size(), 1);
      check("master_rx", r, vecs[i].exp_mrx);
    end
    cpol = 1'b0;
    cpha = 1'b0;
    wr(8'hA5);
    vq.delete();
    @(negedge clk);
    sck = 1'b0;
    #HALF ss = 1'b0;
    #100;
    fork
      begin
        xfer(8'h01, 8, r1);
        xfer(8'h80, 8, r2);
        xfer(8'hFF, 8, r3);
      end
      begin
        #300;
        wr(8'h3C);
      end
    join
    #100;
    release_ss();
    check("b2b_valid_count", vq.size(), 3);
    check("b2b_dout0", vq.size() > 0 ? vq[0] : 8'hxx, 8'h01);
    check("b2b_dout1", vq.size() > 1 ? vq[1] : 8'hxx, 8'h80);
    check("b2b_dout2", vq.size() > 2 ? vq[2] : 8'hxx, 8'hFF);
    check("b2b_rx0", r1, 8'hA5);
    check("b2b_rx1", r2, 8'h3C);
    check("b2b_rx2", r3, 8'h3C);
    wr(8'h5A);
    vq.delete();
    @(negedge clk);
    ss = 1'b0;
    #100;
    xfer(8'hF0, 5, r);
    ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_miso", miso, 1'b0);
    check("abort_miso_oe", miso_oe, 1'b0);
    repeat (10) @(negedge clk);
    check("abort_no_valid", vq.size(), 0);
    check("abort_dout_kept", dout, 8'hFF);
    frame(8'hC3, r);
    release_ss();
    check("post_abort_dout", dout, 8'hC3);
    check("post_abort_rx", r, 8'h5A);
    check("post_abort_valid_count", vq.size(), 1);
    wr(8'h66);
    vq.delete();
    @(negedge clk);
    ss = 1'b0;
    #100;
    xfer(8'h99, 7, r);
    mosi = 1'b1;
    #HALF sck = 1'b1;
    r = {r[6:0], miso};
    #20 check("lat_valid_early", valid, 1'b0);
    #10 check("lat_valid_on", valid, 1'b1);
    #10 check("lat_valid_off", valid, 1'b0);
    #10 sck = 1'b0;
    #100;
    release_ss();
    check("lat_dout", dout, 8'h99);
    check("lat_rx", r, 8'h66);
    check("lat_valid_count", vq.size(), 1);
    @(negedge clk);
    ss = 1'b0;
    #100;
    xfer(8'h55, 3, r);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_miso_oe", miso_oe, 1'b0);
    check("mid_rst_miso", miso, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    ss = 1'b1;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 1'b0);
    vq.delete();
    frame(8'h55, r);
    release_ss();
    check("post_rst_dout", dout, 8'h55);
    check("post_rst_rx", r, 8'h00);
    check("post_rst_valid_count", vq.size(), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits and width of din/dout.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: sck  input  1  SPI serial clock from master; asynchronous to clk.
REQ-005 Port: ss  input  1  slave select, active-low; asynchronous to clk.
REQ-006 Port: mosi  input  1  serial data from master, MSB first.
REQ-007 Port: miso  output  1  serial data to master, MSB first; 0 when not selected.
REQ-008 Port: miso_oe  output  1  output enable for external miso tri-state buffer; equals busy.
REQ-009 Port: cpol  input  1  clock idle level.
REQ-010 Port: cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-011 Port: write  input  1  single-cycle strobe; loads din into the transmit buffer.
REQ-012 Port: din  input  WIDTH  next frame to transmit.
REQ-013 Port: dout  output  WIDTH  last complete received frame.
REQ-014 Port: valid  output  1  one-clk pulse when dout updates.
REQ-015 Port: busy  output  1  high while selected (state ACTIVE).

Function
REQ-016 sck, ss, and mosi SHALL each pass through a 2-flop synchronizer; sck edges SHALL be detected from the synchronized value against a third delayed flop.
REQ-017 Leading edge SHALL be a transition away from cpol, and trailing edge a transition back to cpol.
REQ-018 The sample edge SHALL be the leading edge when cpha=0 and the trailing edge when cpha=1; the other edge SHALL be the shift edge.
REQ-019 cpol and cpha SHALL be latched on the transition IDLE->ACTIVE; changes while ACTIVE SHALL be ignored.
REQ-020 The FSM SHALL have two states: IDLE and ACTIVE.
- IDLE->ACTIVE when synchronized ss falls.
- ACTIVE->IDLE when synchronized ss rises.
REQ-021 On entry to ACTIVE, the bit counter SHALL be set to 0, the tx shift register loaded from the tx buffer, and miso SHALL present tx shift MSB from the next cycle.
REQ-022 On each sample edge, the rx shift register SHALL shift left, taking in synchronized mosi at the LSB, and the bit counter SHALL increment.
REQ-023 On each shift edge, the tx shift register SHALL shift left, zero-filling; exception: when cpha=1, the first leading edge of a frame (bit counter 0) SHALL NOT shift.
REQ-024 On the WIDTH-th sample edge, in the same clk cycle:
- dout SHALL take the full received word, including the bit just sampled.
- valid SHALL pulse high for exactly one clk.
- The bit counter SHALL wrap to 0.
- The tx shift register SHALL reload from the tx buffer at the next shift edge point (cpha=0: the reload replaces that trailing-edge shift; cpha=1: immediately).
REQ-025 Consecutive frames while ss stays low SHALL be supported with no gap cycles required.
REQ-026 Latency: valid SHALL assert on the 3rd rising clk edge after the 8th sample edge on the sck pin.
REQ-027 write SHALL update the tx buffer in any state; a write coincident with a frame load SHALL make the new din the loaded value.
REQ-028 The tx buffer SHALL persist until overwritten, so unrefreshed frames retransmit the same word.
REQ-029 ss deassertion mid-frame SHALL abort the frame:
- The partial rx word is discarded.
- There is no valid pulse and dout is unchanged.
- The FSM returns to IDLE.
- miso=0.
REQ-030 The sck frequency SHALL be at most clk/8; behaviour above this is undefined.

Reset
REQ-031 Reset SHALL asynchronously force:
- state IDLE
- miso=0, miso_oe=0, busy=0, valid=0
- dout=0, tx buffer=0
- shift registers=0, bit counter=0
- synchronizer flops: ss=1, sck=0, mosi=0
REQ-032 Reset asserted mid-frame SHALL discard all progress; after release the block SHALL wait for a fresh ss falling edge.

Verification
REQ-033 Mode 0, 1 frame:
- Stimulus: write din=0xA5; ss low; master sends 0x2A, sck=clk/10.
- Required: dout=0x2A with one valid pulse; master receives 0xA5; busy high only during ss low.
REQ-034 Modes 1/2/3:
- Stimulus: repeat the mode 0 frame for each mode.
- Required: identical results (dout=0x2A, master gets 0xA5); first miso bit correct in cpha=1.
REQ-035 Back-to-back frames:
- Stimulus: ss held low for 3 frames 0x01, 0x80, 0xFF; write 0x3C during frame 1.
- Required: 3 valid pulses with dout 0x01, 0x80, 0xFF; master receives 0xA5, 0x3C, 0x3C.
REQ-036 Abort:
- Stimulus: ss high after 5 sck bits.
- Required: no valid pulse; dout unchanged; busy=0 and miso=0 within 3 clk; next full frame received correctly.
REQ-037 Reset mid-frame:
- Stimulus: reset pulsed after 3 bits.
- Required: all outputs at reset values immediately; subsequent frame 0x55 gives dout=0x55; master receives 0x00.
